// File: rtl/float_multiplier_seq_pkg.sv
`default_nettype none
// ============================================================================
// float_multiplier_seq_pkg : shared FPU constants, FSM states, exponent flags
// Rev 1.0
// ============================================================================
package float_multiplier_seq_pkg;

  localparam int c_FLOAT_SIZE    = 32;
  localparam int c_EXPONENT_SIZE = 8;
  localparam int c_MANTISSA_SIZE = 23;
  localparam int c_BIAS          = 127;

  typedef logic [1:0] fpu_state_t;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_MULT = 2'd1;
  localparam logic [1:0] c_ST_NORM = 2'd2;
  localparam logic [1:0] c_ST_DONE = 2'd3;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } exp_flags_t;

  // The extended exponent is {sign-like msb, flow bit, field}; a set msb means
  // the result went negative, so it wins over the flow bit.
  function automatic exp_flags_t split_exp_flags(input logic msb, input logic flow_bit);
    exp_flags_t f;
    f.underflow = msb;
    f.overflow  = flow_bit & ~msb;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/float_multiplier_seq_mult.sv
`default_nettype none
// ============================================================================
// mantissa_shift_add_mult : iterative shift-and-add mantissa multiplier
// Rev 1.0
// ============================================================================
module mantissa_shift_add_mult
  import float_multiplier_seq_pkg::*;
#(
  parameter int MANTISSA_SIZE = c_MANTISSA_SIZE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [MANTISSA_SIZE:0]       ma,
  input  logic [MANTISSA_SIZE:0]       mb,
  output logic                         done,
  output logic [2*MANTISSA_SIZE+1:0]   product
);

  localparam int c_CNT_W = $clog2(MANTISSA_SIZE + 2);
  localparam int c_PW    = 2 * MANTISSA_SIZE + 2;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(MANTISSA_SIZE);

  logic [MANTISSA_SIZE:0]   r_ma;
  logic [MANTISSA_SIZE:0]   r_mb;
  logic [c_PW-1:0]          r_acc;
  logic [c_CNT_W-1:0]       r_cnt;
  logic                     r_busy;

  logic [MANTISSA_SIZE+1:0] w_addend;
  logic [MANTISSA_SIZE+1:0] w_sum;
  logic [c_PW-1:0]          w_next_acc;

  // Add into the upper half with a carry bit, then shift {carry, acc} right.
  assign w_addend   = r_mb[0] ? {1'b0, r_ma} : '0;
  assign w_sum      = {1'b0, r_acc[c_PW-1:MANTISSA_SIZE+1]} + w_addend;
  assign w_next_acc = {w_sum, r_acc[MANTISSA_SIZE:1]};

  assign done    = r_busy && (r_cnt == c_LAST);
  assign product = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ma   <= '0;
      r_mb   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_ma   <= ma;
      r_mb   <= mb;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_next_acc;
      r_mb  <= r_mb >> 1;
      r_cnt <= r_cnt + 1'b1;
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/float_multiplier_seq.sv
`default_nettype none
// ============================================================================
// float_multiplier_seq : sequential truncating float multiplier, valid/ready
// Rev 1.0
// ============================================================================
module float_multiplier_seq
  import float_multiplier_seq_pkg::*;
#(
  parameter int FLOAT_SIZE    = c_FLOAT_SIZE,
  parameter int EXPONENT_SIZE = c_EXPONENT_SIZE,
  parameter int MANTISSA_SIZE = c_MANTISSA_SIZE,
  parameter int BIAS          = c_BIAS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLOAT_SIZE-1:0] a,
  input  logic [FLOAT_SIZE-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLOAT_SIZE-1:0] out,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  inexact
);

  localparam int c_M  = MANTISSA_SIZE;
  localparam int c_E  = EXPONENT_SIZE;
  localparam int c_XW = EXPONENT_SIZE + 2;

  fpu_state_t          r_state;
  logic                r_sign;
  logic [c_XW-1:0]     r_exp;
  logic [FLOAT_SIZE-1:0] r_out;
  logic                r_overflow;
  logic                r_underflow;
  logic                r_inexact;

  logic                w_accept;
  logic                w_mult_done;
  logic [2*c_M+1:0]    w_product;
  logic [c_M:0]        w_ma;
  logic [c_M:0]        w_mb;
  logic                w_hi;
  logic [c_M-1:0]      w_mant;
  logic                w_inexact;
  logic [c_XW-1:0]     w_exp_final;
  exp_flags_t          w_flags;

  assign in_ready  = (r_state == c_ST_IDLE);
  assign out_valid = (r_state == c_ST_DONE);
  assign w_accept  = in_valid & in_ready;

  // Exponent field 0 still carries an implicit leading one.
  assign w_ma = {1'b1, a[c_M-1:0]};
  assign w_mb = {1'b1, b[c_M-1:0]};

  mantissa_shift_add_mult #(
    .MANTISSA_SIZE (MANTISSA_SIZE)
  ) u_mant_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_accept),
    .ma      (w_ma),
    .mb      (w_mb),
    .done    (w_mult_done),
    .product (w_product)
  );

  // Product is in [1,4); the top bit selects the one-place normalisation.
  assign w_hi        = w_product[2*c_M+1];
  assign w_mant      = w_hi ? w_product[2*c_M:c_M+1] : w_product[2*c_M-1:c_M];
  assign w_inexact   = w_hi ? (|w_product[c_M:0]) : (|w_product[c_M-1:0]);
  assign w_exp_final = r_exp + c_XW'(w_hi);
  assign w_flags     = split_exp_flags(w_exp_final[c_XW-1], w_exp_final[c_XW-2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
      r_sign  <= 1'b0;
      r_exp   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_sign  <= a[FLOAT_SIZE-1] ^ b[FLOAT_SIZE-1];
            r_exp   <= c_XW'(a[FLOAT_SIZE-2:c_M]) + c_XW'(b[FLOAT_SIZE-2:c_M])
                       - c_XW'(BIAS);
            r_state <= c_ST_MULT;
          end
        end
        c_ST_MULT: begin
          if (w_mult_done) begin
            r_state <= c_ST_NORM;
          end
        end
        c_ST_NORM: begin
          r_state <= c_ST_DONE;
        end
        c_ST_DONE: begin
          if (out_ready) begin
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Result and flags are only rewritten in NORM, so they persist through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_inexact   <= 1'b0;
    end else if (r_state == c_ST_NORM) begin
      r_out       <= {r_sign, w_exp_final[c_E-1:0], w_mant};
      r_overflow  <= w_flags.overflow;
      r_underflow <= w_flags.underflow;
      r_inexact   <= w_inexact;
    end
  end

  assign out       = r_out;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign inexact   = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_float_multiplier_seq.sv
`default_nettype none
// ============================================================================
// tb_float_multiplier_seq : directed and random checks against a float model
// Rev 1.0
// ============================================================================
module tb_float_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  float_multiplier_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product of the significands, truncated to 23
  // fraction bits; the unbiased exponent is tracked as a signed integer.
  function automatic logic [34:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint mx, my, p, frac_mask;
    int     sh, e;
    logic [22:0] mant;
    logic [7:0]  ef;
    logic        ov, un, inx;
    mx = 64'h800000 | longint'(x[22:0]);
    my = 64'h800000 | longint'(y[22:0]);
    p  = mx * my;
    sh = (p >= (64'd1 << 47)) ? 1 : 0;
    frac_mask = (64'd1 << (23 + sh)) - 1;
    mant = 23'((p >> (23 + sh)) & 64'h7FFFFF);
    inx  = (p & frac_mask) != 0;
    e    = int'(x[30:23]) + int'(y[30:23]) - 127 + sh;
    un   = (e < 0);
    ov   = (e >= 256);
    ef   = 8'(e & 255);
    return {ov, un, inx, x[31] ^ y[31], ef, mant};
  endfunction

  // Issue one operation, check latency and result, optionally stall in DONE.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input string tag,
                        input int hold);
    int cyc;
    logic [34:0] exp_v;
    logic [34:0] snap;
    logic        stable;
    exp_v = ref_mul(x, y);
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check_val({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check_val({tag, "_latency"}, 64'(cyc), 64'd25);
    check_val({tag, "_result"}, 64'({overflow, underflow, inexact, out}), 64'(exp_v));
    if (hold > 0) begin
      snap = {overflow, underflow, inexact, out};
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if (i == 3) begin
          in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
        end else begin
          in_valid = 1'b0;
        end
        @(posedge clk); #1;
        if ({overflow, underflow, inexact, out} !== snap || !out_valid || in_ready)
          stable = 1'b0;
      end
      in_valid = 1'b0;
      check_val({tag, "_hold_stable"}, 64'(stable), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({tag, "_released"}, 64'({out_valid, in_ready}), 64'b01);
    check_val({tag, "_persist"}, 64'({overflow, underflow, inexact, out}), 64'(exp_v));
  endtask

  initial begin
    logic [31:0] rx, ry;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", 64'({out_valid, overflow, underflow, inexact, out}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check_val("reset_in_ready", 64'(in_ready), 64'd1);

    run_op(32'h3FC00000, 32'h40000000, "d_1p5x2", 0);
    check_val("d_1p5x2_value", 64'(out), 64'h40400000);
    run_op(32'h3FC00000, 32'h3FC00000, "d_1p5x1p5", 0);
    check_val("d_1p5x1p5_value", 64'(out), 64'h40100000);
    run_op(32'h3F800001, 32'h3F800001, "d_inexact", 0);
    check_val("d_inexact_value", 64'({inexact, out}), {31'd0, 1'b1, 32'h3F800002});
    run_op(32'hBFC00000, 32'h3FC00000, "d_sign", 0);
    check_val("d_sign_value", 64'(out), 64'hC0100000);
    run_op(32'h7F000000, 32'h7F000000, "d_ovf", 0);
    check_val("d_ovf_value", 64'({overflow, underflow, out}), {30'd0, 2'b10, 32'h3E800000});
    run_op(32'h00800000, 32'h00800000, "d_unf", 0);
    check_val("d_unf_flags", 64'({overflow, underflow, out[30:23]}), {54'd0, 2'b01, 8'h83});

    run_op(32'h40490FDB, 32'hC02DF854, "d_hold", 10);

    // Reset in the middle of a multiply, after a nonzero result is present.
    a = 32'h3FC00000; b = 32'h3FC00000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("midreset_outputs", 64'({out_valid, overflow, underflow, inexact, out}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check_val("midreset_in_ready", 64'(in_ready), 64'd1);
    run_op(32'h3FC00000, 32'h40000000, "after_reset", 0);
    check_val("after_reset_value", 64'(out), 64'h40400000);

    for (int i = 0; i < 20; i++) begin
      rx = $urandom;
      ry = $urandom;
      run_op(rx, ry, $sformatf("rand%0d", i), (i % 5 == 0) ? 2 : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/float_multiplier_seq.md
Name: float_multiplier_seq

Overview:
- Sequential floating-point multiplier. It is the inverse operation of the combinational float divider.
- Computes a*b for two normalized floats using an iterative shift-and-add mantissa multiply, one multiplier bit per cycle.
- Valid/ready handshake on both input and output, so it can sit in the FPU datapath beside the divider.
- Same flag set as the divider: overflow, underflow, inexact (truncation). No rounding.

Parameters:
- FLOAT_SIZE, 32: total float bit-length.
- EXPONENT_SIZE, 8: exponent field bit-length.
- MANTISSA_SIZE, 23: stored mantissa bit-length (hidden 1 not stored).
- BIAS, 127: exponent bias.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  FLOAT_SIZE  multiplicand float, format [S|E|M].
- b  input  FLOAT_SIZE  multiplier float.
- out_valid  output  1  result and flags are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- out  output  FLOAT_SIZE  product float.
- overflow  output  1  exponent overflow occurred.
- underflow  output  1  exponent underflow occurred.
- inexact  output  1  nonzero product bits were truncated.

Behaviour:
- **Reset** (rst_n=0, asynchronous, also mid-operation):
  - state goes to IDLE; all registers clear.
  - out, overflow, underflow, inexact = 0; out_valid = 0; in_ready = 1 once rst_n=1.
  - A partially computed product is discarded.
- **States:** IDLE -> MULT -> NORM -> DONE -> IDLE.
- **IDLE:** in_valid & in_ready captures a and b at edge T, then goes to MULT.
  - Sign register = sign_a ^ sign_b.
  - Exponent register (EXPONENT_SIZE+2 bits, zero-extended) = exp_a + exp_b - BIAS.
  - ma = {1,mant_a}, mb = {1,mant_b}, each MANTISSA_SIZE+1 bits.
  - Product accumulator (2*MANTISSA_SIZE+2 bits) = 0; iteration counter = 0.
- **MULT:** one iteration per cycle, exactly MANTISSA_SIZE+1 iterations, LSB of mb first.
  - If the current mb bit is 1, add ma into the upper half of the accumulator.
  - Then shift {carry, accumulator} right by 1 and shift mb right by 1.
  - The last iteration occurs at edge T+MANTISSA_SIZE+1, then the state goes to NORM.
  - in_valid is ignored while busy.
- **NORM:** product P lies in [1,4). Let M = MANTISSA_SIZE.
  - If P[2M+1]=1: mantissa_out = P[2M:M+1], discarded bits = P[M:0], exponent +1.
  - Else: mantissa_out = P[2M-1:M], discarded bits = P[M-1:0], exponent +0.
  - inexact = OR of the discarded bits.
  - {underflow, flow_bit, exponent_out} = final (EXPONENT_SIZE+2)-bit exponent; overflow = flow_bit & ~underflow.
  - exponent_out is the wrapped low EXPONENT_SIZE bits. No saturation, no denormal/inf/NaN handling.
  - Exponent field 0 is still treated as having a hidden 1.
  - out = {sign, exponent_out, mantissa_out}; go to DONE at edge T+M+2.
- **DONE:** out_valid = 1.
  - out and flags are held stable until out_valid & out_ready, then go to IDLE and drop out_valid.
  - out and flags keep their last values in IDLE until the next NORM.
- **Latency:** out_valid is high from edge T+MANTISSA_SIZE+2, i.e. 25 cycles for the defaults.
  - Throughput is one operation per MANTISSA_SIZE+3 cycles or more; no overlap of operations.
- **Iteration counter:** width $clog2(MANTISSA_SIZE+2); it must not wrap before the last iteration.

Decomposition:
- Shared fpu package holds:
  - The state enum {IDLE, MULT, NORM, DONE}.
  - The default FLOAT_SIZE/EXPONENT_SIZE/MANTISSA_SIZE/BIAS constants.
  - A function for the extended-width exponent flag split, reused by the divider.
- One natural sub-module: mantissa_shift_add_mult.
  - Holds the counter, accumulator and multiplier register.
  - Interface: start/done, operand inputs, product output.
  - The top level keeps the FSM, exponent and flag logic.

Test Plan:
- 0x3FC00000 * 0x40000000 (1.5*2.0) -> out=0x40400000, all flags 0, out_valid exactly 25 cycles after the accept edge.
- 0x3FC00000 * 0x3FC00000 (1.5*1.5, normalization path) -> out=0x40100000, flags 0.
- 0x3F800001 * 0x3F800001 -> out=0x3F800002, inexact=1. Also 0xBFC00000 * 0x3FC00000 -> out=0xC0100000 (sign check).
- 0x7F000000 * 0x7F000000 -> overflow=1, underflow=0, exponent_out=125 (out=0x3E800000).
- 0x00800000 * 0x00800000 -> underflow=1, overflow=0, exponent_out=0x83.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles in DONE -> out/flags stable, in_ready=0, a second in_valid pulse ignored.
  - Assert rst_n=0 mid-MULT -> outputs 0 immediately, then the next operation completes correctly.
